// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption: forward key expansion to K32, then 31 inverse rounds.
// Optional K1/K32 cache lets a repeated key skip the expansion phase.
module present_decrypt_core #(
    parameter int KEY_CACHE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] idat,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] odat,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] dreg_q, dreg_d;
    logic [79:0] kreg_q, kreg_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [79:0] ck1_q, ck1_d;
    logic [79:0] ck32_q, ck32_d;
    logic        cvld_q, cvld_d;
    logic        hit;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] isbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
            4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
            4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
            4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] kupd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ i;
        return r;
    endfunction

    function automatic logic [79:0] kinv(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] x;
        x = k;
        x[19:15] = x[19:15] ^ i;
        x[79:76] = isbox(x[79:76]);
        return {x[60:0], x[79:61]};
    endfunction

    // Undo pLayer first, then the S-box layer, then strip the round key.
    function automatic logic [63:0] inv_round(input logic [63:0] d, input logic [63:0] rk);
        logic [63:0] p;
        logic [63:0] s;
        for (int j = 0; j < 63; j++) p[j] = d[(16 * j) % 63];
        p[63] = d[63];
        for (int n = 0; n < 16; n++) s[4*n +: 4] = isbox(p[4*n +: 4]);
        return s ^ rk;
    endfunction

    assign hit       = (KEY_CACHE != 0) && cvld_q && (key == ck1_q);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == KEYEXP) || (state_q == DEC);
    assign odat      = dreg_q;

    always_comb begin
        state_d = state_q;
        dreg_d  = dreg_q;
        kreg_d  = kreg_q;
        rnd_d   = rnd_q;
        ck1_d   = ck1_q;
        ck32_d  = ck32_q;
        cvld_d  = cvld_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (hit) begin
                        dreg_d  = idat ^ ck32_q[79:16];
                        kreg_d  = ck32_q;
                        rnd_d   = 5'd31;
                        state_d = DEC;
                    end else begin
                        dreg_d  = idat;
                        kreg_d  = key;
                        ck1_d   = key;
                        cvld_d  = 1'b0;
                        rnd_d   = 5'd1;
                        state_d = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                kreg_d = kupd(kreg_q, rnd_q);
                rnd_d  = rnd_q + 5'd1;
                if (rnd_q == 5'd31) begin
                    dreg_d  = dreg_q ^ kreg_d[79:16];
                    ck32_d  = kreg_d;
                    cvld_d  = 1'b1;
                    rnd_d   = 5'd31;
                    state_d = DEC;
                end
            end
            DEC: begin
                kreg_d = kinv(kreg_q, rnd_q);
                dreg_d = inv_round(dreg_q, kreg_d[79:16]);
                rnd_d  = rnd_q - 5'd1;
                if (rnd_q == 5'd1) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dreg_q  <= '0;
            kreg_q  <= '0;
            rnd_q   <= '0;
            ck1_q   <= '0;
            ck32_q  <= '0;
            cvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dreg_q  <= dreg_d;
            kreg_q  <= kreg_d;
            rnd_q   <= rnd_d;
            ck1_q   <= ck1_d;
            ck32_q  <= ck32_d;
            cvld_q  <= cvld_d;
        end
    end

endmodule

// File: tb/tb_present_decrypt_core.sv
// Bench for present_decrypt_core: cached and uncached instances share inputs,
// checked against known PRESENT-80 vectors and a forward-encryption model.
module tb_present_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] idat = '0;
    logic [79:0] key = '0;
    logic        rdy1, ov1, busy1, rdy0, ov0, busy0;
    logic [63:0] od1, od0;

    int total = 0;
    int bad = 0;
    logic [79:0] last_key = '0;
    bit          cache_ok = 1'b0;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always #5 clk = ~clk;

    present_decrypt_core #(.KEY_CACHE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .idat(idat), .key(key), .out_valid(ov1), .out_ready(out_ready),
        .odat(od1), .busy(busy1)
    );

    present_decrypt_core #(.KEY_CACHE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .idat(idat), .key(key), .out_valid(ov0), .out_ready(out_ready),
        .odat(od0), .busy(busy0)
    );

    // Forward PRESENT-80 encryption built from a table of round keys.
    function automatic logic [63:0] ref_enc(input logic [79:0] k, input logic [63:0] p);
        logic [79:0] ks;
        logic [63:0] rk [1:32];
        logic [63:0] s, t;
        ks = k;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = ks[79:16];
            ks = (ks << 61) | (ks >> 19);
            ks[79:76] = SB[ks[79:76]];
            ks[19:15] = ks[19:15] ^ r[4:0];
        end
        s = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
            for (int j = 0; j < 64; j++) s[(j == 63) ? 63 : (j * 16) % 63] = t[j];
        end
        return s ^ rk[32];
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [79:0] k, input logic [63:0] c, input logic [63:0] p,
                           input bit early, input int hold, input string tag);
        int lat1, lat0, exp1;
        logic [63:0] cap1, cap0;
        logic [95:0] rnd96;
        exp1 = (cache_ok && k == last_key) ? 31 : 62;
        cap1 = '0;
        cap0 = '0;
        @(negedge clk);
        chk({tag, ".in_ready"}, 80'({rdy1, rdy0}), 80'(2'b11));
        in_valid  = 1'b1;
        idat      = c;
        key       = k;
        out_ready = early;
        @(posedge clk);
        #1 in_valid = 1'b0;
        idat = {$urandom, $urandom};
        lat1 = 0;
        lat0 = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (ov1 && lat1 == 0) begin lat1 = n; cap1 = od1; end
            if (ov0 && lat0 == 0) begin lat0 = n; cap0 = od0; end
            if (lat1 != 0 && lat0 != 0) break;
        end
        chk({tag, ".lat_cache"}, 80'(lat1), 80'(exp1));
        chk({tag, ".lat_nocache"}, 80'(lat0), 80'(62));
        chk({tag, ".pt_cache"}, 80'(cap1), 80'(p));
        chk({tag, ".pt_nocache"}, 80'(cap0), 80'(p));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                in_valid = h[0];
                idat = {$urandom, $urandom};
                rnd96 = {$urandom, $urandom, $urandom};
                key = rnd96[79:0];
                @(posedge clk);
                #1;
                chk({tag, ".hold_flags"}, 80'({ov1, ov0, rdy1, rdy0}), 80'(4'b1100));
                chk({tag, ".hold_odat1"}, 80'(od1), 80'(p));
                chk({tag, ".hold_odat0"}, 80'(od0), 80'(p));
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, ".released"}, 80'({ov1, ov0, rdy1, rdy0, busy1, busy0}), 80'(6'b001100));
        last_key = k;
        cache_ok = 1'b1;
    endtask

    initial begin
        logic [79:0] rk;
        logic [95:0] r96;
        logic [63:0] p, c;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.flags1", 80'({rdy1, ov1, busy1}), 80'(3'b100));
        chk("reset.flags0", 80'({rdy0, ov0, busy0}), 80'(3'b100));
        chk("reset.odat1", 80'(od1), 80'(0));
        chk("reset.odat0", 80'(od0), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_job(80'h0, 64'h5579C1387B228445, 64'h0, 1'b0, 0, "t1");
        run_job({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 1'b0, 0, "t2a");
        run_job({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}}, 1'b0, 0, "t2b");
        run_job(80'h0, 64'hA112FFC72F68417B, {64{1'b1}}, 1'b0, 10, "t3");
        run_job(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1, 0, "early");

        // Abort a miss job at DEC round 15, then rerun the same key.
        @(negedge clk);
        in_valid = 1'b1;
        idat = 64'hE72C46C0F5945049;
        key = {80{1'b1}};
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (47) @(posedge clk);
        #1;
        chk("abort.busy_before", 80'({busy1, busy0}), 80'(2'b11));
        rst_n = 1'b0;
        #1;
        chk("abort.flags1", 80'({rdy1, ov1, busy1}), 80'(3'b100));
        chk("abort.flags0", 80'({rdy0, ov0, busy0}), 80'(3'b100));
        @(negedge clk);
        rst_n = 1'b1;
        cache_ok = 1'b0;
        run_job({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 1'b0, 0, "after_abort");

        rk = '0;
        for (int j = 0; j < 500; j++) begin
            if (j % 3 == 0) begin
                r96 = {$urandom, $urandom, $urandom};
                rk = r96[79:0];
            end
            p = {$urandom, $urandom};
            c = ref_enc(rk, p);
            run_job(rk, c, p, (j % 7 == 0), (j % 50 == 1) ? 2 : 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
